aes_decipher: RTL and testbench

Iterative AES inverse cipher (FIPS-197 §5.3) for Nk = 4/6/8 (AES-128/192/256). It computes one inverse round per clock and is the decrypt-side counterpart of the team's iterative encipher. Ciphertext and key are captured on a start handshake. The plaintext is presented with a one-cycle done pulse and held until the next result. The key schedule comes from the team's existing combinational Key_Expansion module, driven from the internally latched key.

---
 rtl/aes_decipher_pkg.sv | 91 +++++++++
 rtl/aes_decipher_if.sv | 12 +
 rtl/Key_Expansion.sv | 48 ++++
 rtl/aes_decipher_inv_round.sv | 35 +++
 rtl/aes_decipher.sv | 118 +++++++++++
 tb/tb_aes_decipher.sv | 154 +++++++++++++++
 6 files changed

// File: rtl/aes_decipher_pkg.sv
// Shared AES constants, S-box tables, GF(2^8) helpers and FSM encoding
// for the iterative inverse cipher and its key schedule.
package aes_decipher_pkg;

   localparam int NB      = 4;
   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      FINAL = 2'd3
   } state_t;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Inverse S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant through an xtime chain.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] p;
      logic [7:0] acc;
      p   = a;
      acc = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // InvMixColumns on one column, byte 0 at the MSB end.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

endpackage

// File: rtl/aes_decipher_if.sv
// Start/result handshake bundle between a requester and aes_decipher.
interface aes_decipher_if #(parameter int Nk = 4) ();
   logic           start;
   logic [127:0]   ct_in;
   logic [Nk*32-1:0] key;
   logic           busy;
   logic           done;
   logic [127:0]   pt_out;

   modport master (output start, ct_in, key, input busy, done, pt_out);
   modport slave  (input start, ct_in, key, output busy, done, pt_out);
endinterface

// File: rtl/Key_Expansion.sv
// Combinational AES key schedule: Nr+1 round keys, word 0 at the MSB end.
module Key_Expansion
   import aes_decipher_pkg::*;
#(
   parameter int Nk = 4
) (
   input  logic [Nk*32-1:0]          key,
   output logic [(4*Nk+28)*32-1:0]   k_sch
);

   localparam int NW    = 4 * Nk + 28;
   localparam int SCH_W = NW * 32;

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [SCH_W-1:0] expand(input logic [Nk*32-1:0] k);
      logic [31:0]      w [0:NW-1];
      logic [31:0]      t;
      logic [7:0]       rc;
      logic [SCH_W-1:0] s;
      rc = 8'h01;
      s  = '0;
      for (int i = 0; i < NW; i++) begin
         if (i < Nk) begin
            w[i] = k[Nk*32-1-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % Nk == 0) begin
               t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
               rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
         end
         s[SCH_W-1-32*i -: 32] = w[i];
      end
      return s;
   endfunction

   // Whole schedule is a pure function of the latched key.
   always_comb begin
      k_sch = expand(key);
   end

endmodule

// File: rtl/aes_decipher_inv_round.sv
// One equivalent-order inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
module aes_decipher_inv_round
   import aes_decipher_pkg::*;
(
   input  logic [127:0] in_state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] out_state
);

   logic [127:0] sub_add;
   logic [127:0] mixed;

   // Row r of column c reads column (c - r) mod 4 of the input state.
   always_comb begin
      sub_add = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sub_add[127-8*(4*c+r) -: 8] =
               inv_sbox(in_state[127-8*(4*((c+4-r)%4)+r) -: 8]) ^ rk[127-8*(4*c+r) -: 8];
         end
      end
   end

   // Column-wise InvMixColumns, bypassed on the final round.
   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[127-32*c -: 32] = inv_mix_col(sub_add[127-32*c -: 32]);
      end
      out_state = last ? sub_add : mixed;
   end

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128/192/256 inverse cipher, one inverse round per clock.
module aes_decipher
   import aes_decipher_pkg::*;
#(
   parameter int Nk = 4
) (
   input  logic          clk,
   input  logic          reset,
   aes_decipher_if.slave bus
);

   localparam int NR    = Nk + 6;
   localparam int SCH_W = (4 * NR + 4) * 32;

   state_t            fsm, fsm_next;
   logic [3:0]        cnt;
   logic [127:0]      ct_q;
   logic [Nk*32-1:0]  key_q;
   logic [127:0]      st;
   logic [127:0]      pt_q;
   logic              busy_q;
   logic              done_q;

   logic [SCH_W-1:0]  k_sch;
   logic [127:0]      rk_arr [0:NR];
   logic [3:0]        rk_idx;
   logic [127:0]      rk;
   logic [127:0]      round_out;

   Key_Expansion #(.Nk(Nk)) u_key_exp (
      .key   (key_q),
      .k_sch (k_sch)
   );

   for (genvar i = 0; i <= NR; i++) begin : g_rk
      assign rk_arr[i] = k_sch[SCH_W-1-128*i -: 128];
   end

   // Round-key select: last key on LOAD, counter in ROUND, key 0 on FINAL.
   always_comb begin
      rk_idx = cnt;
      case (fsm)
         LOAD:    rk_idx = 4'(NR);
         FINAL:   rk_idx = 4'd0;
         default: rk_idx = cnt;
      endcase
      rk = rk_arr[rk_idx];
   end

   aes_decipher_inv_round u_round (
      .in_state  (st),
      .rk        (rk),
      .last      (fsm == FINAL),
      .out_state (round_out)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) fsm <= IDLE;
      else       fsm <= fsm_next;
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      fsm_next = fsm;
      case (fsm)
         IDLE:    if (bus.start) fsm_next = LOAD;
         LOAD:    fsm_next = ROUND;
         ROUND:   if (cnt == 4'd1) fsm_next = FINAL;
         FINAL:   fsm_next = IDLE;
         default: fsm_next = IDLE;
      endcase
   end

   // Datapath and status registers; everything clears on reset so an abort
   // leaves no partial result behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         ct_q   <= '0;
         key_q  <= '0;
         st     <= '0;
         pt_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm)
            IDLE: begin
               if (bus.start) begin
                  ct_q   <= bus.ct_in;
                  key_q  <= bus.key;
                  busy_q <= 1'b1;
               end
            end
            LOAD: begin
               st  <= ct_q ^ rk;
               cnt <= 4'(NR - 1);
            end
            ROUND: begin
               st <= round_out;
               if (cnt != 4'd1) cnt <= cnt - 4'd1;
            end
            FINAL: begin
               pt_q   <= round_out;
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.pt_out = pt_q;

endmodule

// File: tb/tb_aes_decipher.sv
// Directed-vector bench for aes_decipher at Nk = 4, 6 and 8.
module tb_aes_decipher;
   import aes_decipher_pkg::*;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   sel   = 4;

   always #5 clk = ~clk;

   aes_decipher_if #(.Nk(4)) if4 ();
   aes_decipher_if #(.Nk(6)) if6 ();
   aes_decipher_if #(.Nk(8)) if8 ();

   aes_decipher #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
   aes_decipher #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .bus(if6.slave));
   aes_decipher #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

   logic         s_busy, s_done;
   logic [127:0] s_pt;

   always_comb begin
      s_busy = if4.busy;
      s_done = if4.done;
      s_pt   = if4.pt_out;
      case (sel)
         6: begin s_busy = if6.busy; s_done = if6.done; s_pt = if6.pt_out; end
         8: begin s_busy = if8.busy; s_done = if8.done; s_pt = if8.pt_out; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where start was just raised; returns at the
   // negedge of the done cycle (or after the cycle budget runs out).
   task automatic wait_done(input int lat, input logic [127:0] exp_pt,
                            input string tag, input bit disturb);
      int n       = -1;
      bit busy_ok = 1'b1;
      for (int i = 1; i <= lat + 4; i++) begin
         @(negedge clk);
         if (i == 1) begin if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0; end
         if (disturb && i == 4) begin
            if4.start = 1'b1; if4.ct_in = CT_B; if4.key = KEY_B;
         end
         if (disturb && i == 5) if4.start = 1'b0;
         if (s_done) begin n = i; break; end
         if (s_busy !== 1'b1) busy_ok = 1'b0;
      end
      chk({tag, "_latency"}, 128'(n), 128'(lat));
      chk({tag, "_busy_high"}, 128'(busy_ok), 128'(1));
      chk({tag, "_busy_low_at_done"}, 128'(s_busy), 128'(0));
      chk({tag, "_pt"}, s_pt, exp_pt);
   endtask

   initial begin
      reset = 1'b1;
      if4.start = 1'b0; if4.ct_in = '0; if4.key = '0;
      if6.start = 1'b0; if6.ct_in = '0; if6.key = '0;
      if8.start = 1'b0; if8.ct_in = '0; if8.key = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 128'(if4.busy), 128'(0));
      chk("reset_done", 128'(if4.done), 128'(0));
      chk("reset_pt", if4.pt_out, 128'h0);
      reset = 1'b0;
      @(negedge clk);

      // AES-128 App. C.1
      sel = 4;
      if4.ct_in = CT_C1; if4.key = KEY_C1; if4.start = 1'b1;
      wait_done(12, PT_C, "c1", 1'b0);

      // AES-128 App. B, then single-cycle pulse and held result
      @(negedge clk);
      if4.ct_in = CT_B; if4.key = KEY_B; if4.start = 1'b1;
      wait_done(12, PT_B, "appb", 1'b0);
      @(negedge clk);
      chk("appb_done_pulse", 128'(if4.done), 128'(0));
      chk("appb_pt_held", if4.pt_out, PT_B);

      // C.1 with a second start and new ct/key mid-operation
      if4.ct_in = CT_C1; if4.key = KEY_C1; if4.start = 1'b1;
      wait_done(12, PT_C, "disturb", 1'b1);

      // Start accepted in the done cycle itself
      if4.ct_in = CT_B; if4.key = KEY_B; if4.start = 1'b1;
      wait_done(12, PT_B, "b2b", 1'b0);

      // AES-192
      @(negedge clk);
      sel = 6;
      if6.ct_in = CT_C2; if6.key = KEY_C2; if6.start = 1'b1;
      wait_done(14, PT_C, "c2_nk6", 1'b0);

      // AES-256
      @(negedge clk);
      sel = 8;
      if8.ct_in = CT_C3; if8.key = KEY_C3; if8.start = 1'b1;
      wait_done(16, PT_C, "c3_nk8", 1'b0);

      // Reset part way through the rounds
      @(negedge clk);
      sel = 4;
      if4.ct_in = CT_C1; if4.key = KEY_C1; if4.start = 1'b1;
      @(negedge clk);
      if4.start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_abort_busy", 128'(if4.busy), 128'(1));
      reset = 1'b1;
      #1;
      chk("abort_busy", 128'(if4.busy), 128'(0));
      chk("abort_done", 128'(if4.done), 128'(0));
      chk("abort_pt", if4.pt_out, 128'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      begin
         bit saw_done = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if4.done) saw_done = 1'b1;
         end
         chk("abort_no_done", 128'(saw_done), 128'(0));
         chk("abort_pt_after", if4.pt_out, 128'h0);
      end

      // Fresh start after the abort
      if4.ct_in = CT_C1; if4.key = KEY_C1; if4.start = 1'b1;
      wait_done(12, PT_C, "post_abort", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
